// File: rtl/sad_window_feeder.sv
// Template/candidate feeder for the 17-phase SAD accumulator, with winner-take-all tracking.
// Optional macro WTA_TIE_LAST_EN: ties go to the highest candidate index instead of the lowest.
module sad_window_feeder #(
  parameter int FRAME_LEN = 17,
  parameter int BLK       = 16,
  parameter int IDX_W     = 8
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic             Tpl_We,
  input  logic [3:0]       Tpl_Addr,
  input  logic [7:0]       Tpl_Data,
  input  logic             Start,
  input  logic [IDX_W-1:0] Num_Cand,
  input  logic             Cand_Valid,
  input  logic [7:0]       Cand_Data,
  output logic             Cand_Ready,
  output logic [7:0]       X,
  output logic [7:0]       T,
  input  logic [11:0]      Dist_In,
  output logic             Busy,
  output logic             Done,
  output logic [11:0]      Best_Dist,
  output logic [IDX_W-1:0] Best_Idx
);

  localparam int PH_W = $clog2(FRAME_LEN);
  localparam int BI_W = $clog2(BLK);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(FRAME_LEN - 1);
  localparam logic [PH_W-1:0] PH_BEAT  = PH_W'(BLK - 1);
  localparam logic [BI_W:0]   FILL_END = (BI_W+1)'(BLK - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_ALIGN, S_STREAM, S_LATCH, S_CAPTURE, S_DONE
  } state_t;

  state_t           state;
  logic [PH_W-1:0]  ph;
  logic [BI_W:0]    fill_cnt;
  logic [IDX_W-1:0] num_cand;
  logic [IDX_W-1:0] cand_idx;
  logic [7:0]       tpl      [BLK];
  logic [7:0]       cand_buf [BLK];

  logic [IDX_W-1:0] next_idx;
  logic             last_cand;
  logic             cand_accept;
  logic             better;
  logic [BI_W-1:0]  beat_next;

  assign next_idx    = cand_idx + 1'b1;
  assign last_cand   = (next_idx == num_cand);
  // The next block may start filling in the capture cycle, since streaming of the old one is over.
  assign Cand_Ready  = (state == S_FILL) || ((state == S_CAPTURE) && !last_cand);
  assign cand_accept = Cand_Valid && Cand_Ready;
  assign beat_next   = BI_W'(ph + 1'b1);

`ifdef WTA_TIE_LAST_EN
  assign better = (Dist_In <= Best_Dist);
`else
  assign better = (Dist_In < Best_Dist);
`endif

  // Template and candidate storage carry no reset: the template survives reset by design.
  always_ff @(posedge Clk) begin
    if (RstN && Tpl_We && (state == S_IDLE))
      tpl[Tpl_Addr] <= Tpl_Data;
    if (RstN && cand_accept)
      cand_buf[fill_cnt[BI_W-1:0]] <= Cand_Data;
  end

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      state     <= S_IDLE;
      ph        <= '0;
      fill_cnt  <= '0;
      num_cand  <= '0;
      cand_idx  <= '0;
      X         <= '0;
      T         <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Best_Dist <= 12'hFFF;
      Best_Idx  <= '0;
    end else begin
      ph   <= (ph == PH_LAST) ? '0 : ph + 1'b1;
      Done <= 1'b0;
      X    <= '0;
      T    <= '0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            Best_Dist <= 12'hFFF;
            Best_Idx  <= '0;
            num_cand  <= Num_Cand;
            cand_idx  <= '0;
            fill_cnt  <= '0;
            if (Num_Cand == '0) begin
              state <= S_DONE;
              Done  <= 1'b1;
            end else begin
              Busy  <= 1'b1;
              state <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (cand_accept) begin
            if (fill_cnt == FILL_END) begin
              fill_cnt <= '0;
              state    <= S_ALIGN;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
        end
        S_ALIGN: begin
          // Preload beat 0 so it is on X/T exactly when the accumulator sees ph 0.
          if (ph == PH_LAST) begin
            state <= S_STREAM;
            X     <= cand_buf[0];
            T     <= tpl[0];
          end
        end
        S_STREAM: begin
          if (ph == PH_BEAT) begin
            state <= S_LATCH;
          end else begin
            X <= cand_buf[beat_next];
            T <= tpl[beat_next];
          end
        end
        S_LATCH: state <= S_CAPTURE;
        S_CAPTURE: begin
          if (better) begin
            Best_Dist <= Dist_In;
            Best_Idx  <= cand_idx;
          end
          cand_idx <= next_idx;
          if (last_cand) begin
            state <= S_DONE;
            Done  <= 1'b1;
            Busy  <= 1'b0;
          end else begin
            state <= S_FILL;
            if (cand_accept)
              fill_cnt <= (BI_W+1)'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sad_window_feeder.md
Name: sad_window_feeder

Overview:
- Upstream partner of the 16-pixel Manhattan-distance (SAD) accumulator.
- Holds a 16-byte template and buffers one 16-byte candidate block at a time.
- Drives the template/candidate pixel pairs (T, X) to the accumulator in its fixed 17-phase frame, then reads back the 12-bit distance.
- Tracks the winner-take-all minimum over a programmed number of candidates and reports the best index and distance.

Parameters:
- FRAME_LEN, 17, phases per accumulator frame: 16 data beats plus 1 latch phase.
- BLK, 16, pixels per block.
- IDX_W, 8, width of the candidate count and index.

Ports:
- Clk  in  1  system clock, rising edge.
- RstN  in  1  reset, synchronous, active-low.
- Tpl_We  in  1  template write strobe.
- Tpl_Addr  in  4  template byte address.
- Tpl_Data  in  8  template byte.
- Start  in  1  one-cycle pulse that begins a search.
- Num_Cand  in  IDX_W  number of candidates; sampled on Start.
- Cand_Valid  in  1  candidate byte valid.
- Cand_Data  in  8  candidate byte, 16 consecutive accepted bytes per block.
- Cand_Ready  out  1  feeder accepts a candidate byte this cycle.
- X  out  8  candidate pixel to the accumulator.
- T  out  8  template pixel to the accumulator.
- Dist_In  in  12  distance (WTA) returned by the accumulator.
- Busy  out  1  search in progress.
- Done  out  1  one-cycle pulse when the search completes.
- Best_Dist  out  12  minimum distance found.
- Best_Idx  out  IDX_W  index of the minimum, 0-based.

Behaviour:
- Phase counter `ph` is free-running 0..16 and wraps from 16 to 0. It clears to 0 on reset, in lockstep with the accumulator, which is reset by the same RstN.
- Reset values: X=0, T=0, Cand_Ready=0, Busy=0, Done=0, Best_Dist=12'hFFF, Best_Idx=0. Template contents are retained; the state machine goes to IDLE.
- Template writes:
  - Accepted only in IDLE.
  - Ignored while Busy.
- IDLE:
  - On Start with Num_Cand=0: go straight to DONE. Best_Dist=FFF, Best_Idx=0.
  - On Start otherwise: latch Num_Cand, set cand_idx=0, set Best_Dist=FFF, set Busy=1, go to FILL.
  - Start while Busy is ignored.
- FILL:
  - Cand_Ready=1 while fewer than 16 bytes are buffered.
  - A byte is accepted when Cand_Valid & Cand_Ready, and is written at buffer position 0..15 in order.
  - Gaps in Cand_Valid are allowed.
  - After the 16th byte, Cand_Ready=0 and the state moves to ALIGN.
- ALIGN:
  - Wait until ph==16.
  - On the next cycle (ph==0), enter STREAM.
- STREAM (ph 0..15):
  - X=cand_buf[ph], T=tpl[ph], both registered outputs.
  - The accumulator cannot stall, so all 16 beats are contiguous.
- LATCH (ph==16):
  - X=T=0.
  - Next state is CAPTURE.
- CAPTURE (ph==0 of the next frame):
  - Dist_In now holds the distance for this block.
  - If Dist_In < Best_Dist (strict compare): Best_Dist<=Dist_In, Best_Idx<=cand_idx.
  - Then cand_idx+1. If cand_idx+1 == Num_Cand, go to DONE; otherwise go to FILL.
  - FILL may begin accepting the next block in this same cycle.
- Idle drive: outside STREAM, X=T=0, so any frame the accumulator runs without data yields 0 and is never captured.
- DONE:
  - Done=1 for exactly one cycle, Busy=0, then IDLE.
  - Best_Dist and Best_Idx hold until the next Start.
- Throughput: at least 2 frames per candidate (fill overlaps alignment), at most FRAME_LEN*2 plus fill stall.
- Reset asserted mid-operation: the synchronous clear applies on the next edge, any partial block is discarded, and no Done pulse is issued.

Optional Feature:
- Macro: WTA_TIE_LAST_EN.
- Defined: the compare is Dist_In <= Best_Dist, so on ties the highest index wins.
- Undefined (default): strict <, so the earliest index wins.

Test Plan:
- Template all 10 (8'h0A); 3 candidates: all 20, all 10, all 12, fed back-to-back with the accumulator model in the bench → Done once; Best_Idx=1, Best_Dist=0.
- Single candidate with bytes 0..15 against template all 0, Cand_Valid toggled every other cycle → STREAM still 16 contiguous beats aligned to ph 0; X sequence is 0..15; Best_Dist=120, Best_Idx=0.
- Two candidates both at distance 32 → Best_Idx=0 without the macro; Best_Idx=1 with WTA_TIE_LAST_EN.
- Start with Num_Cand=0 → Done one cycle after Start; Best_Dist=12'hFFF, Best_Idx=0; X/T stay 0.
- Tpl_We during Busy with Tpl_Data=8'hFF → template is unchanged; search result is identical to the run without the write.
- RstN low for one cycle during STREAM beat 7 → next cycle X=T=0, Busy=0, Best_Dist=FFF; no Done; a new Start then completes normally.
